seq_divider: RTL and testbench

Sequential restoring divider. It is the inverse companion to the radix-8 Booth multiplier: a 2W-bit dividend is divided by a W-bit divisor, giving a W-bit quotient and a W-bit remainder. It uses the same Start/Done handshake and control-plus-counter style as the multiplier, so a test unit can drive multiply and divide through identical sequencing. It computes one quotient bit per clock.

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/div_iter_counter.sv | 28 ++
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential multiply/divide control blocks.
package seq_divider_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider; flags the final iteration while enabled.
module div_iter_counter #(
  parameter int unsigned max = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = (max > 1) ? $clog2(max) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == CW'(max - 1)) ? '0 : count + CW'(1);
    end
  end

  assign done = en && (count == CW'(max - 1));

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, Start/Done handshake.
// Optional DIV_OVERFLOW_CHECK_EN: early exit with error on divide-by-zero/overflow.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           done,
  output logic           busy,
  output logic           error,
  output logic [1:0]     state
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  logic         start_acc;
  logic         last_iter;
  logic [W:0]   rs;
  logic [W:0]   diff;
  logic         ge;

  assign start_acc = (state_q == IDLE) && start;

  div_iter_counter #(.max(W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (state_q == RUN),
    .done (last_iter)
  );

  // Stored R always stays below D, so W bits hold it; the shifted value needs W+1.
  always_comb begin
    rs   = {r_q, q_q[W-1]};
    ge   = (rs >= {1'b0, d_q});
    diff = rs - {1'b0, d_q};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          r_d     = dividend[2*W-1:W];
          q_d     = dividend[W-1:0];
          d_d     = divisor;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef DIV_OVERFLOW_CHECK_EN
          if ((divisor == '0) || (dividend[2*W-1:W] >= divisor)) begin
            err_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        r_d = ge ? W'(diff) : W'(rs);
        q_d = {q_q[W-2:0], ge};
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        quo_d   = q_q;
        rem_d   = r_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign error     = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain integer division model.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           done;
  logic           busy;
  logic           error;
  logic [1:0]     state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .error     (error),
    .state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, return cycles from acceptance edge to Done plus captured results.
  task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                        output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic e);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
    e = error;
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("busy_falls_with_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [W-1:0] q, r, q1, r1;
    logic e;
    logic [2*W-1:0] a_dvd, b_dvd;
    logic [W-1:0] a_dvs, b_dvs, hi;

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    run_op(16'd200, 8'd7, lat, q, r, e);
    chk("200_7_lat", 32'(lat), 32'd9);
    chk("200_7_q", 32'(q), 32'd28);
    chk("200_7_r", 32'(r), 32'd4);
    chk("200_7_err", 32'(e), 32'd0);

    run_op(16'h1234, 8'h56, lat, q, r, e);
    chk("1234_56_q", 32'(q), 32'h36);
    chk("1234_56_r", 32'(r), 32'h10);

    run_op(16'hFE01, 8'hFF, lat, q, r, e);
    chk("fe01_ff_q", 32'(q), 32'hFF);
    chk("fe01_ff_r", 32'(r), 32'h00);

    run_op(16'h1234, 8'h00, lat, q, r, e);
`ifdef DIV_OVERFLOW_CHECK_EN
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_err", 32'(e), 32'd1);
    chk("div0_q", 32'(q), 32'hFF);
    chk("div0_r", 32'(r), 32'h00);
`else
    chk("div0_lat", 32'(lat), 32'd9);
    chk("div0_err", 32'(e), 32'd0);
`endif

    run_op(16'h1000, 8'h10, lat, q, r, e);
`ifdef DIV_OVERFLOW_CHECK_EN
    chk("ovf_lat", 32'(lat), 32'd1);
    chk("ovf_err", 32'(e), 32'd1);
    chk("ovf_q", 32'(q), 32'hFF);
    chk("ovf_r", 32'(r), 32'h00);
`else
    chk("ovf_lat", 32'(lat), 32'd9);
    chk("ovf_err", 32'(e), 32'd0);
`endif

    // Second Start with different operands during RUN must be ignored.
    @(negedge clk);
    dividend = 16'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    q1 = '0;
    r1 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("ignore_state_run", 32'(state), 32'd1);
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          q1 = quotient;
          r1 = remainder;
        end
      end
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_q", 32'(q1), 32'd28);
    chk("ignore_r", 32'(r1), 32'd4);

    // Reset during the 4th RUN cycle aborts with no Done.
    @(negedge clk);
    dividend = 16'h1234;
    divisor  = 8'h56;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    run_op(16'd100, 8'd9, lat, q, r, e);
    chk("100_9_q", 32'(q), 32'd11);
    chk("100_9_r", 32'(r), 32'd1);

    for (int n = 0; n < 20; n++) begin
      a_dvs = 8'($urandom_range(255, 1));
      hi    = 8'($urandom_range(32'(a_dvs) - 1, 0));
      a_dvd = {hi, 8'($urandom)};
      run_op(a_dvd, a_dvs, lat, q, r, e);
      chk("rand_lat", 32'(lat), 32'd9);
      chk("rand_q", 32'(q), 32'(a_dvd / a_dvs));
      chk("rand_r", 32'(r), 32'(a_dvd % a_dvs));
      chk("rand_err", 32'(e), 32'd0);
    end

    // Start held high: second acceptance right after Done, results held in between.
    a_dvs = 8'($urandom_range(255, 1));
    hi    = 8'($urandom_range(32'(a_dvs) - 1, 0));
    a_dvd = {hi, 8'($urandom)};
    b_dvs = 8'($urandom_range(255, 1));
    hi    = 8'($urandom_range(32'(b_dvs) - 1, 0));
    b_dvd = {hi, 8'($urandom)};
    @(negedge clk);
    dividend = a_dvd;
    divisor  = a_dvs;
    start    = 1'b1;
    @(negedge clk);
    dividend = b_dvd;
    divisor  = b_dvs;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_a_lat", 32'(lat), 32'd9);
    chk("b2b_a_q", 32'(quotient), 32'(a_dvd / a_dvs));
    chk("b2b_a_r", 32'(remainder), 32'(a_dvd % a_dvs));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_busy_reaccept", 32'(busy), 32'd1);
    chk("b2b_state_run", 32'(state), 32'd1);
    chk("b2b_hold_q", 32'(quotient), 32'(a_dvd / a_dvs));
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 5) chk("b2b_hold_r", 32'(remainder), 32'(a_dvd % a_dvs));
    end
    chk("b2b_b_lat", 32'(lat), 32'd9);
    chk("b2b_b_q", 32'(quotient), 32'(b_dvd / b_dvs));
    chk("b2b_b_r", 32'(remainder), 32'(b_dvd % b_dvs));
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
